// File: rtl/fp_round_stage.sv
// Rounding stage behind the 12-bit int-to-float converter: round-half-up with
// exponent carry and saturation, a 2-entry output FIFO and a saturation event counter.
module fp_round_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_s,
  input  logic [2:0]       in_e,
  input  logic [3:0]       in_f,
  input  logic             in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [2:0]       out_e,
  output logic [3:0]       out_f,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; ready never depends combinationally on the opposite side's ready, and a
  // presented output stays stable until it is taken.

  // Entry layout: {sat, s, e[2:0], f[3:0]}
  logic [8:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic [3:0] rnd_f;
  logic [2:0] rnd_e;
  logic       rnd_sat;

  always_comb begin
    rnd_f   = in_f;
    rnd_e   = in_e;
    rnd_sat = 1'b0;
    if (in_r) begin
      if (in_f != 4'b1111) begin
        rnd_f = in_f + 4'd1;
      end else if (in_e != 3'b111) begin
        // Significand overflow renormalises to 1.000 with the next exponent
        rnd_f = 4'b1000;
        rnd_e = in_e + 3'd1;
      end else begin
        rnd_sat = 1'b1;
      end
    end
  end

  assign in_ready  = ~rst & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign {out_sat, out_s, out_e, out_f} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      sat_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {rnd_sat, in_s, rnd_e, rnd_f};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && rnd_sat && (sat_cnt != {CNT_W{1'b1}})) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_stage.sv
// Directed bench for fp_round_stage: the driver queues hand-computed results,
// a negedge monitor pops and compares whenever the DUT hands one downstream.
module tb_fp_round_stage;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_s;
  logic [2:0]       in_e;
  logic [3:0]       in_f;
  logic             in_r;
  logic             out_valid;
  logic             out_ready;
  logic             out_s;
  logic [2:0]       out_e;
  logic [3:0]       out_f;
  logic             out_sat;
  logic [CNT_W-1:0] sat_cnt;

  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  fp_round_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_e(in_e), .in_f(in_f), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_sat(out_sat),
    .sat_cnt(sat_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Driver: present one input, wait for acceptance, queue the expected {sat,s,e,f}
  task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f,
                      input logic r, input logic [8:0] exp, output int waits);
    in_valid = 1'b1;
    in_s = s; in_e = e; in_f = f; in_r = r;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none", {out_sat, out_s, out_e, out_f});
      end else begin
        check("out_entry", {out_sat, out_s, out_e, out_f}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; in_s = 0; in_e = 0; in_f = 0; in_r = 0; out_ready = 1'b0;

    // Reset then idle
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ef", {out_e, out_f}, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Basic rounding
    out_ready = 1'b1;
    send(1'b0, 3'b011, 4'b1010, 1'b1, 9'b0_0_011_1011, w);
    send(1'b1, 3'b101, 4'b1100, 1'b0, 9'b0_1_101_1100, w);
    // Exponent carry and saturation
    send(1'b0, 3'b010, 4'b1111, 1'b1, 9'b0_0_011_1000, w);
    send(1'b0, 3'b111, 4'b1111, 1'b1, 9'b1_0_111_1111, w);
    check("sat_cnt_1", sat_cnt, 1);
    drain();

    // Backpressure: A and B fill the FIFO, C must wait
    out_ready = 1'b0;
    send(1'b1, 3'b001, 4'b0011, 1'b1, 9'b0_1_001_0100, w);
    send(1'b0, 3'b110, 4'b0111, 1'b0, 9'b0_0_110_0111, w);
    in_valid = 1'b1; in_s = 1'b1; in_e = 3'b111; in_f = 4'b1111; in_r = 1'b1;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_head_held", {out_sat, out_s, out_e, out_f}, 9'b0_1_001_0100);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1'b1, 3'b111, 4'b1111, 1'b1, 9'b1_1_111_1111, w);
    check("c_waited", (w > 0), 1);
    drain();
    check("sat_cnt_2", sat_cnt, 2);

    // Streaming: one accepted per cycle with simultaneous push/pop
    for (int i = 0; i < 10; i++) begin
      logic [3:0] f;
      f = i[3:0];
      send(i[0], 3'b010, f, i[0], {1'b0, i[0], 3'b010, f + {3'b000, i[0]}}, w);
      check("stream_no_stall", w, 0);
    end
    drain();

    // Counter saturation at 3 for CNT_W=2
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 3'b111, 4'b1111, 1'b1, 9'b1_0_111_1111, w);
    end
    check("sat_cnt_hold", sat_cnt, 3);
    drain();

    // Mid-operation reset with two entries buffered
    out_ready = 1'b0;
    send(1'b0, 3'b001, 4'b0001, 1'b0, 9'b0_0_001_0001, w);
    send(1'b1, 3'b100, 4'b0110, 1'b1, 9'b0_1_100_0111, w);
    @(negedge clk);
    check("pre_rst_full", {out_valid, in_ready}, 2'b10);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1; in_s = 1'b0; in_e = 3'b111; in_f = 4'b1111; in_r = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sat_cnt", sat_cnt, 0);
    check("mid_rst_out_entry", {out_sat, out_s, out_e, out_f}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_idle", out_valid, 0);

    // Operation resumes after reset
    out_ready = 1'b1;
    send(1'b1, 3'b000, 4'b0101, 1'b1, 9'b0_1_000_0110, w);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish expected finish");
    $fatal(1);
  end

endmodule
